// File: rtl/uc_pkg.sv
// Shared definitions for the microc control unit: opcodes, FSM states,
// ALU codes and the raw control bundle passed from decoder to sequencer.
package uc_pkg;

  localparam logic [5:0] OP_J    = 6'b010000;
  localparam logic [5:0] OP_JZ   = 6'b010001;
  localparam logic [5:0] OP_JNZ  = 6'b010010;
  localparam logic [5:0] OP_JAL  = 6'b010011;
  localparam logic [5:0] OP_RET  = 6'b010100;
  localparam logic [5:0] OP_HALT = 6'b010101;
  localparam logic [5:0] OP_JR   = 6'b010110;
  localparam logic [3:0] OP_LI   = 4'b0000;  // matched against opcode[5:2]
  localparam logic       OP_ALU_PREFIX = 1'b1;  // matched against opcode[5]

  localparam logic [2:0] ALU_OP_NONE = 3'b000;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } uc_state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_CALL = 2'd1,
    REQ_RET  = 2'd2,
    REQ_HALT = 2'd3
  } uc_req_e;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       s_rre;
    logic       s_ret;
    logic       we3;
    logic       wez;
    logic [2:0] op;
    logic       pc_en;
    logic       push;
    logic       pop;
  } uc_ctrl_t;

endpackage

// File: rtl/uc_decode.sv
// Pure combinational opcode/z decoder; produces controls as if the unit
// were running, plus a request telling the sequencer about calls/returns/halt.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output uc_ctrl_t   ctrl,
  output uc_req_e    req
);

  always_comb begin
    ctrl       = '0;
    ctrl.op    = ALU_OP_NONE;
    ctrl.pc_en = 1'b1;
    req        = REQ_NONE;
    if (opcode[5] == OP_ALU_PREFIX) begin
      ctrl.op    = opcode[4:2];
      ctrl.we3   = 1'b1;
      ctrl.wez   = 1'b1;
      ctrl.s_inc = 1'b1;
    end else if (opcode[5:2] == OP_LI) begin
      ctrl.s_inm = 1'b1;
      ctrl.we3   = 1'b1;
      ctrl.s_inc = 1'b1;
    end else begin
      case (opcode)
        OP_J:   ctrl.s_inc = 1'b0;
        OP_JZ:  ctrl.s_inc = ~z;
        OP_JNZ: ctrl.s_inc = z;
        OP_JAL: begin
          ctrl.push = 1'b1;
          req       = REQ_CALL;
        end
        OP_RET: begin
          ctrl.s_ret = 1'b1;
          ctrl.pop   = 1'b1;
          req        = REQ_RET;
        end
        OP_HALT: begin
          ctrl.pc_en = 1'b0;
          req        = REQ_HALT;
        end
        OP_JR:   ctrl.s_rre = 1'b1;
        default: ctrl.s_inc = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_ctrl.sv
// microc control unit: wraps uc_decode with the INIT/RUN/HALT/FAULT
// sequencer and a call-depth counter that faults on stack over/underflow.
module uc_ctrl
  import uc_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               z,
  output logic               s_inc,
  output logic               s_inm,
  output logic               s_rre,
  output logic               s_ret,
  output logic               we3,
  output logic               wez,
  output logic [2:0]         op,
  output logic               pc_en,
  output logic               push,
  output logic               pop,
  output logic               halted,
  output logic               fault,
  output uc_state_e          state_dbg,
  output logic [DEPTH_W-1:0] depth_dbg
);

  uc_state_e          state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  uc_ctrl_t           raw_ctrl, ctrl;
  uc_req_e            req;

  uc_decode u_decode (
    .opcode (opcode),
    .z      (z),
    .ctrl   (raw_ctrl),
    .req    (req)
  );

  // Outside RUN the PC holds and nothing is written; s_inc stays at PC+1.
  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    ctrl       = '0;
    ctrl.s_inc = 1'b1;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        ctrl = raw_ctrl;
        case (req)
          REQ_CALL: begin
            if (depth_q < DEPTH_W'(STACK_DEPTH)) begin
              depth_d = depth_q + DEPTH_W'(1);
            end else begin
              ctrl    = '0;
              state_d = ST_FAULT;
            end
          end
          REQ_RET: begin
            if (depth_q != '0) begin
              depth_d = depth_q - DEPTH_W'(1);
            end else begin
              ctrl    = '0;
              state_d = ST_FAULT;
            end
          end
          REQ_HALT: state_d = ST_HALT;
          default:  state_d = ST_RUN;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
    end
  end

  assign s_inc     = ctrl.s_inc;
  assign s_inm     = ctrl.s_inm;
  assign s_rre     = ctrl.s_rre;
  assign s_ret     = ctrl.s_ret;
  assign we3       = ctrl.we3;
  assign wez       = ctrl.wez;
  assign op        = ctrl.op;
  assign pc_en     = ctrl.pc_en;
  assign push      = ctrl.push;
  assign pop       = ctrl.pop;
  assign halted    = (state_q == ST_HALT);
  assign fault     = (state_q == ST_FAULT);
  assign state_dbg = state_q;
  assign depth_dbg = depth_q;

endmodule

// File: tb/tb_uc_ctrl.sv
// Self-checking bench for uc_ctrl: a decode vector table applied in RUN,
// plus hand sequences for init, stack overflow/underflow, halt and async reset.
module tb_uc_ctrl;
  import uc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       z;
  logic       s_inc, s_inm, s_rre, s_ret, we3, wez, pc_en, push, pop, halted, fault;
  logic [2:0] op;
  uc_state_e  state_dbg;
  logic [3:0] depth_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [13:0] exp_q[$];

  typedef struct {
    string       name;
    logic [5:0]  opc;
    logic        zf;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  uc_ctrl #(.STACK_DEPTH(4), .DEPTH_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .z         (z),
    .s_inc     (s_inc),
    .s_inm     (s_inm),
    .s_rre     (s_rre),
    .s_ret     (s_ret),
    .we3       (we3),
    .wez       (wez),
    .op        (op),
    .pc_en     (pc_en),
    .push      (push),
    .pop       (pop),
    .halted    (halted),
    .fault     (fault),
    .state_dbg (state_dbg),
    .depth_dbg (depth_dbg)
  );

  always #5 clk = ~clk;

  // Bit order: s_inc s_inm s_rre s_ret we3 wez op[2:0] pc_en push pop halted fault
  function automatic logic [13:0] mk(input logic si, input logic sm, input logic sr,
                                     input logic st, input logic w3, input logic wz,
                                     input logic [2:0] o, input logic pe, input logic pu,
                                     input logic po, input logic h, input logic f);
    return {si, sm, sr, st, w3, wz, o, pe, pu, po, h, f};
  endfunction

  function automatic logic [13:0] got();
    return {s_inc, s_inm, s_rre, s_ret, we3, wez, op, pc_en, push, pop, halted, fault};
  endfunction

  task automatic check_ctrl(input string name);
    logic [13:0] e;
    e = exp_q.pop_front();
    n_tests++;
    if (got() !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (si sm sr st w3 wz op pe pu po h f)", name, got(), e);
    end
  endtask

  task automatic expect_ctrl(input string name, input logic [13:0] e);
    exp_q.push_back(e);
    check_ctrl(name);
  endtask

  task automatic check_sd(input string name, input uc_state_e st, input logic [3:0] d);
    n_tests++;
    if (state_dbg !== st || depth_dbg !== d) begin
      n_fail++;
      $display("FAIL %s: state=%0d depth=%0d expected state=%0d depth=%0d",
               name, state_dbg, depth_dbg, st, d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input logic zf);
    opcode = o;
    z      = zf;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    check_sd("reset_async", ST_INIT, 4'd0);
    reset = 1'b0;
    #1;
    drive(6'b000000, 1'b0);
    expect_ctrl("init_cycle", mk(1,0,0,0,0,0,3'b000,0,0,0,0,0));
    tick();
  endtask

  logic [13:0] v_init, v_halt, v_fault, v_dead, v_jal, v_ret;

  initial begin
    v_init  = mk(1,0,0,0,0,0,3'b000,0,0,0,0,0);
    v_halt  = mk(1,0,0,0,0,0,3'b000,0,0,0,1,0);
    v_fault = mk(1,0,0,0,0,0,3'b000,0,0,0,0,1);
    v_dead  = mk(0,0,0,0,0,0,3'b000,0,0,0,0,0);
    v_jal   = mk(0,0,0,0,0,0,3'b000,1,1,0,0,0);
    v_ret   = mk(0,0,0,1,0,0,3'b000,1,0,1,0,0);

    vecs.push_back('{"alu_101",  6'b110100, 1'b0, mk(1,0,0,0,1,1,3'b101,1,0,0,0,0)});
    vecs.push_back('{"alu_000",  6'b100011, 1'b1, mk(1,0,0,0,1,1,3'b000,1,0,0,0,0)});
    vecs.push_back('{"alu_111",  6'b111110, 1'b0, mk(1,0,0,0,1,1,3'b111,1,0,0,0,0)});
    vecs.push_back('{"li",       6'b000011, 1'b0, mk(1,1,0,0,1,0,3'b000,1,0,0,0,0)});
    vecs.push_back('{"j",        6'b010000, 1'b1, mk(0,0,0,0,0,0,3'b000,1,0,0,0,0)});
    vecs.push_back('{"jz_z1",    6'b010001, 1'b1, mk(0,0,0,0,0,0,3'b000,1,0,0,0,0)});
    vecs.push_back('{"jz_z0",    6'b010001, 1'b0, mk(1,0,0,0,0,0,3'b000,1,0,0,0,0)});
    vecs.push_back('{"jnz_z1",   6'b010010, 1'b1, mk(1,0,0,0,0,0,3'b000,1,0,0,0,0)});
    vecs.push_back('{"jnz_z0",   6'b010010, 1'b0, mk(0,0,0,0,0,0,3'b000,1,0,0,0,0)});
    vecs.push_back('{"jr",       6'b010110, 1'b0, mk(0,0,1,0,0,0,3'b000,1,0,0,0,0)});
    vecs.push_back('{"nop_0101", 6'b010111, 1'b0, mk(1,0,0,0,0,0,3'b000,1,0,0,0,0)});
    vecs.push_back('{"nop_011",  6'b011111, 1'b1, mk(1,0,0,0,0,0,3'b000,1,0,0,0,0)});
    vecs.push_back('{"nop_001",  6'b001000, 1'b0, mk(1,0,0,0,0,0,3'b000,1,0,0,0,0)});

    // Reset and INIT
    reset  = 1'b1;
    opcode = 6'b000000;
    z      = 1'b0;
    #3;
    expect_ctrl("reset_outputs", v_init);
    check_sd("reset_state", ST_INIT, 4'd0);
    #7;
    reset = 1'b0;
    #2;
    expect_ctrl("first_cycle_init", v_init);
    tick();
    check_sd("run_after_init", ST_RUN, 4'd0);
    expect_ctrl("li_after_init", mk(1,1,0,0,1,0,3'b000,1,0,0,0,0));
    tick();

    // Decode table
    foreach (vecs[i]) begin
      drive(vecs[i].opc, vecs[i].zf);
      exp_q.push_back(vecs[i].exp);
      check_ctrl(vecs[i].name);
      tick();
    end
    check_sd("table_end_state", ST_RUN, 4'd0);

    // Call depth overflow
    for (int i = 0; i < 4; i++) begin
      drive(OP_JAL, 1'b0);
      check_sd("jal_depth", ST_RUN, 4'(i));
      expect_ctrl("jal_push", v_jal);
      tick();
    end
    drive(OP_JAL, 1'b0);
    check_sd("jal5_depth", ST_RUN, 4'd4);
    expect_ctrl("jal5_overflow", v_dead);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive((i == 0) ? 6'b110100 : OP_RET, 1'b0);
      expect_ctrl("fault_held", v_fault);
      check_sd("fault_frozen", ST_FAULT, 4'd4);
      tick();
    end
    do_reset();

    // Call/return and underflow
    drive(OP_JAL, 1'b0);
    expect_ctrl("call_push", v_jal);
    tick();
    drive(OP_RET, 1'b0);
    check_sd("ret_depth1", ST_RUN, 4'd1);
    expect_ctrl("ret_pop", v_ret);
    tick();
    drive(OP_RET, 1'b0);
    check_sd("ret_depth0", ST_RUN, 4'd0);
    expect_ctrl("ret_underflow", v_dead);
    tick();
    drive(OP_JAL, 1'b0);
    expect_ctrl("underflow_fault", v_fault);
    check_sd("underflow_state", ST_FAULT, 4'd0);
    tick();
    do_reset();

    // HALT and async reset
    drive(OP_JAL, 1'b0);
    expect_ctrl("pre_halt_call", v_jal);
    tick();
    drive(OP_HALT, 1'b0);
    expect_ctrl("halt_op", v_dead);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive((i == 1) ? OP_JAL : 6'b000001, 1'b0);
      expect_ctrl("halt_held", v_halt);
      check_sd("halt_state", ST_HALT, 4'd1);
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (halted !== 1'b0 || pc_en !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_halted: halted=%b pc_en=%b expected halted=0 pc_en=0",
               halted, pc_en);
    end
    check_sd("async_reset_state", ST_INIT, 4'd0);
    #1;
    reset = 1'b0;
    #1;
    expect_ctrl("post_reset_init", v_init);
    tick();
    drive(6'b110100, 1'b0);
    expect_ctrl("post_reset_run", mk(1,0,0,0,1,1,3'b101,1,0,0,0,0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_ctrl.md
Name: uc_ctrl

Overview:
- Control unit for the microc single-cycle datapath; the counterpart that drives the control inputs the datapath consumes.
- Decodes the 6-bit `opcode` and the zero flag `z` into the datapath controls:
  - `s_inc`, `s_inm`, `s_rre`, `s_ret` (selects)
  - `we3`, `wez` (write enables)
  - `op[2:0]` (ALU operation)
- Adds sequential supervision on top of the decode: a post-reset init cycle, a HALT state, PC hold, and a call-depth tracker with overflow/underflow fault detection.

Parameters:
- STACK_DEPTH, 4, number of return-address entries the datapath stack holds; range 1..15.
- DEPTH_W, 4, width of the depth counter; must satisfy 2^DEPTH_W > STACK_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  opcode field of the current instruction, from the datapath.
- z  in  1  registered zero flag from the datapath.
- s_inc  out  1  1 = PC+1, 0 = jump target.
- s_inm  out  1  1 = register file write data comes from the immediate.
- s_rre  out  1  1 = jump target comes from register read port 1 (JR).
- s_ret  out  1  1 = next PC comes from the return stack top.
- we3  out  1  register file write enable.
- wez  out  1  zero-flag write enable.
- op  out  3  ALU operation.
- pc_en  out  1  PC register load enable.
- push  out  1  return stack push (PC+1).
- pop  out  1  return stack pop.
- halted  out  1  high in the HALT state.
- fault  out  1  high in the FAULT state.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Controls are combinational (Mealy) from opcode, z and the state, valid in the same cycle as the opcode. Registered state is `state` and `depth`.
- States: INIT, RUN, HALT, FAULT.
- Reset effect: reset asserted forces state=INIT and depth=0 immediately, including mid-instruction.
- INIT:
  - Outputs: pc_en=0, we3=0, wez=0, push=0, pop=0, s_inc=1, s_inm=0, s_rre=0, s_ret=0, op=000, halted=0, fault=0.
  - Unconditionally moves to RUN after one clock.
- RUN decode. Any output not listed is 0; pc_en=1 unless stated otherwise.
  - 1ooo xx, ALU: op=opcode[4:2], we3=1, wez=1, s_inc=1.
  - 0000 xx, LI: s_inm=1, we3=1, s_inc=1.
  - 010000, J: s_inc=0.
  - 010001, JZ: s_inc=~z.
  - 010010, JNZ: s_inc=z.
  - 010011, JAL:
    - if depth<STACK_DEPTH: s_inc=0, push=1, depth+1.
    - else: pc_en=0, push=0, next state FAULT.
  - 010100, RET:
    - if depth>0: s_ret=1, pop=1, depth-1.
    - else: pc_en=0, pop=0, next state FAULT.
  - 010101, HALT: pc_en=0, next state HALT.
  - 010110, JR: s_rre=1, s_inc=0.
  - All other codes are NOP: s_inc=1, no writes.
- HALT:
  - Outputs: pc_en=0, all writes/push/pop=0, halted=1.
  - Exits only via reset.
- FAULT:
  - Same outputs as HALT but halted=0, fault=1.
  - depth is frozen; exits only via reset.
- No write enable or stack strobe is ever asserted outside RUN.
- depth never wraps. A JAL at depth==STACK_DEPTH and a RET at depth==0 are the only fault triggers.

Decomposition:
- Package uc_pkg holds:
  - opcode constants (OP_LI, OP_J, OP_JZ, OP_JNZ, OP_JAL, OP_RET, OP_HALT, OP_JR, OP_ALU_PREFIX);
  - state encoding (ST_INIT, ST_RUN, ST_HALT, ST_FAULT);
  - ALU op codes.
- Sub-module uc_decode: a pure combinational opcode/z to raw controls decoder.
- uc_ctrl wraps uc_decode with the state machine and depth counter, and gates the raw controls by state.

Test Plan:
- Reset and INIT:
  - Stimulus: reset=1 for 10 ns, release; opcode=000000.
  - Required: first cycle pc_en=0, we3=0. Next cycle RUN with s_inm=1, we3=1, s_inc=1, pc_en=1.
- ALU decode:
  - Stimulus: opcode=110100.
  - Required: op=101, we3=1, wez=1, s_inc=1, s_inm=0.
- Conditional jumps:
  - Stimulus: JZ with z=1, then z=0.
  - Required: s_inc=0 then 1. JNZ gives the inverse.
- Call depth overflow:
  - Stimulus: 4 consecutive JAL with STACK_DEPTH=4, then a 5th JAL.
  - Required: push=1 on each of the first 4. On the 5th: push=0, pc_en=0, then fault=1 held until reset.
- Call/return and underflow:
  - Stimulus: JAL, RET, RET.
  - Required: push, then pop with s_ret=1. The second RET gives pop=0 and fault=1.
- HALT and async reset:
  - Stimulus: opcode=010101; then assert reset mid-cycle.
  - Required: halted=1, pc_en=0 held across 3 cycles. Reset clears halted immediately with no clock edge, and depth=0.
